// File: rtl/tt_scanner.sv
// Truth-table scanner: steps a 3-input vector through 000..111, waits a settle
// time per vector, samples the function output and compares against a golden table.
module tt_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic       pass
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TBL_W = 8;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TBL_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // With no settle time each vector goes straight to its sample cycle.
    localparam state_e VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   abc_q, abc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic               pass_q, pass_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = VEC_ENTRY;
                    k_d     = '0;
                    cnt_d   = SETTLE_LOAD;
                    abc_d   = '0;
                    busy_d  = 1'b1;
                    table_d = '0;
                    pass_d  = 1'b0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[k_q] = s_in;
                if (k_q == LAST_IDX) begin
                    state_d = DONE;
                    k_d     = '0;
                    abc_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = ((table_d ^ EXPECTED) == 8'h00);
                end else begin
                    state_d = VEC_ENTRY;
                    k_d     = k_q + IDX_W'(1);
                    abc_d   = k_q + IDX_W'(1);
                    cnt_d   = SETTLE_LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            pass_q  <= pass_d;
        end
    end

    assign a         = abc_q[2];
    assign b         = abc_q[1];
    assign c         = abc_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;
    // Live view: tracks the partial table during a scan.
    assign mismatch  = table_q ^ EXPECTED;

endmodule
